lab1_imul_int_mul_var: RTL

Parametrised, variable-latency iterative integer multiplier. It is the next generation of the fixed-latency shift-add multiplier in the lab1_imul subsystem, with three additions: a configurable operand width, RISC-V style MUL/MULH/MULHSU/MULHU modes, and early termination once the remaining multiplier bits are zero. It sits behind the same val/rdy istream/ostream interfaces and is a drop-in for the 32-bit block when p_nbits=32 and op=MUL.

---
 rtl/lab1_imul_pkg.sv | 69 ++++++
 rtl/lab1_imul_int_mul_var_ctrl.sv | 107 ++++++++++
 rtl/lab1_imul_int_mul_var_dpath.sv | 152 +++++++++++++++
 rtl/lab1_imul_int_mul_var.sv | 71 +++++++
 4 files changed

// File: rtl/lab1_imul_pkg.sv
// -----------------------------------------------------------------------------
// lab1_imul_pkg
// Shared types and message layout helpers for the variable-latency iterative
// integer multiplier (lab1_imul_int_mul_var and its ctrl/dpath sub-modules).
//
// Contents:
//   op_e        multiply mode carried in the request message
//   state_e     control FSM states
//   msg_*()     bit offsets of the request fields as a function of width N
//   op_*_signed whether an operand is interpreted as two's complement
// -----------------------------------------------------------------------------
package lab1_imul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,  // low N bits of the product
        OP_MULH   = 2'b01,  // signed x signed, high N bits
        OP_MULHSU = 2'b10,  // signed a x unsigned b, high N bits
        OP_MULHU  = 2'b11   // unsigned x unsigned, high N bits
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned OP_W = 2;

    // Request layout: {op, a, b}, each operand N bits wide.
    function automatic int unsigned msg_b_lsb(input int unsigned n);
        return 0;
    endfunction

    function automatic int unsigned msg_b_msb(input int unsigned n);
        return n - 1;
    endfunction

    function automatic int unsigned msg_a_lsb(input int unsigned n);
        return n;
    endfunction

    function automatic int unsigned msg_a_msb(input int unsigned n);
        return 2 * n - 1;
    endfunction

    function automatic int unsigned msg_op_lsb(input int unsigned n);
        return 2 * n;
    endfunction

    function automatic int unsigned msg_op_msb(input int unsigned n);
        return 2 * n + OP_W - 1;
    endfunction

    function automatic int unsigned msg_width(input int unsigned n);
        return 2 * n + OP_W;
    endfunction

    // MUL is treated as signed x signed: the low half of the product is the
    // same either way, and taking magnitudes keeps small negative
    // multipliers on the short (early-terminating) path.
    function automatic logic op_a_signed(input op_e op);
        return (op != OP_MULHU);
    endfunction

    function automatic logic op_b_signed(input op_e op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/lab1_imul_int_mul_var_ctrl.sv
// -----------------------------------------------------------------------------
// lab1_imul_int_mul_var_ctrl
// Control FSM (IDLE -> CALC -> DONE) for the iterative multiplier. DONE can
// hand off directly to CALC when a new request arrives in the same cycle the
// response is taken.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   i_istream_val       request valid
//   o_istream_rdy       request ready
//   o_ostream_val       response valid
//   i_ostream_rdy       response ready
//   o_load, o_acc_clr   start a new operation in the datapath
//   o_shift, o_add_en   one iteration, with or without accumulate
//   i_b_lsb             current multiplier bit
//   i_b_next_zero       remaining multiplier bits are zero after this step
//   i_count_done        last possible iteration
// -----------------------------------------------------------------------------
module lab1_imul_int_mul_var_ctrl
    import lab1_imul_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_istream_val,
    output logic o_istream_rdy,
    output logic o_ostream_val,
    input  logic i_ostream_rdy,
    output logic o_load,
    output logic o_acc_clr,
    output logic o_shift,
    output logic o_add_en,
    input  logic i_b_lsb,
    input  logic i_b_next_zero,
    input  logic i_count_done
);

    state_e r_state;
    state_e w_state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        o_istream_rdy = 1'b0;
        o_ostream_val = 1'b0;
        o_load        = 1'b0;
        o_acc_clr     = 1'b0;
        o_shift       = 1'b0;
        o_add_en      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                o_istream_rdy = 1'b1;
                if (i_istream_val) begin
                    o_load       = 1'b1;
                    o_acc_clr    = 1'b1;
                    w_state_next = ST_CALC;
                end
            end

            ST_CALC: begin
                o_shift  = 1'b1;
                o_add_en = i_b_lsb;
                // Stop as soon as no set multiplier bits remain.
                if (i_b_next_zero || i_count_done) begin
                    w_state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                o_ostream_val = 1'b1;
                // A new request can only enter while the response leaves.
                o_istream_rdy = i_ostream_rdy;
                if (i_ostream_rdy) begin
                    if (i_istream_val) begin
                        o_load       = 1'b1;
                        o_acc_clr    = 1'b1;
                        w_state_next = ST_CALC;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Handshakes are suppressed while reset is asserted.
        if (reset) begin
            o_istream_rdy = 1'b0;
            o_ostream_val = 1'b0;
            o_load        = 1'b0;
            o_acc_clr     = 1'b0;
            o_shift       = 1'b0;
            o_add_en      = 1'b0;
        end
    end

endmodule

// File: rtl/lab1_imul_int_mul_var_dpath.sv
// -----------------------------------------------------------------------------
// lab1_imul_int_mul_var_dpath
// Datapath of the iterative shift-add multiplier. Operates on magnitudes and
// applies the sign once at the end.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   i_istream_msg       request {op, a, b}
//   o_ostream_msg       selected half of the signed/unsigned product
//   i_load              capture operand magnitudes, op and result sign
//   i_acc_clr           clear the accumulator
//   i_shift             one iteration: shift a left, b right, count up
//   i_add_en            add the shifted multiplicand into the accumulator
//   o_b_lsb             current multiplier bit
//   o_b_next_zero       multiplier becomes zero after this iteration
//   o_count_done        this is the N-th iteration
// -----------------------------------------------------------------------------
module lab1_imul_int_mul_var_dpath
    import lab1_imul_pkg::*;
#(
    parameter int unsigned p_nbits = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [msg_width(p_nbits)-1:0]  i_istream_msg,
    output logic [p_nbits-1:0]             o_ostream_msg,
    input  logic                           i_load,
    input  logic                           i_acc_clr,
    input  logic                           i_shift,
    input  logic                           i_add_en,
    output logic                           o_b_lsb,
    output logic                           o_b_next_zero,
    output logic                           o_count_done
);

    localparam int unsigned N      = p_nbits;
    localparam int unsigned W2     = 2 * p_nbits;
    localparam int unsigned CW     = $clog2(p_nbits);
    localparam int unsigned OP_LSB = msg_op_lsb(p_nbits);
    localparam int unsigned OP_MSB = msg_op_msb(p_nbits);
    localparam int unsigned A_LSB  = msg_a_lsb(p_nbits);
    localparam int unsigned A_MSB  = msg_a_msb(p_nbits);
    localparam int unsigned B_LSB  = msg_b_lsb(p_nbits);
    localparam int unsigned B_MSB  = msg_b_msb(p_nbits);
    localparam logic [CW-1:0] COUNT_LAST = CW'(p_nbits - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    // ---------------------------------------------------------------------
    // Request decode and magnitude extraction
    // ---------------------------------------------------------------------
    op_e            w_op;
    logic [N-1:0]   w_a;
    logic [N-1:0]   w_b;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [N-1:0]   w_a_mag;
    logic [N-1:0]   w_b_mag;

    assign w_op    = op_e'(i_istream_msg[OP_MSB:OP_LSB]);
    assign w_a     = i_istream_msg[A_MSB:A_LSB];
    assign w_b     = i_istream_msg[B_MSB:B_LSB];
    assign w_a_neg = op_a_signed(w_op) & w_a[N-1];
    assign w_b_neg = op_b_signed(w_op) & w_b[N-1];
    // Negating the most-negative value yields 2^(N-1), which is exactly
    // representable as an unsigned N-bit magnitude.
    assign w_a_mag = w_a_neg ? -w_a : w_a;
    assign w_b_mag = w_b_neg ? -w_b : w_b;

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    logic [W2-1:0]  r_a;
    logic [N-1:0]   r_b;
    logic [W2-1:0]  r_acc;
    logic [CW-1:0]  r_count;
    logic           r_neg;
    op_e            r_op;

    // Multiplicand: zero-extended magnitude, shifted left each iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a <= '0;
        end else if (i_load) begin
            r_a <= {{N{1'b0}}, w_a_mag};
        end else if (i_shift) begin
            r_a <= r_a << 1;
        end
    end

    // Multiplier: logical right shift exposes the next bit in r_b[0].
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b <= '0;
        end else if (i_load) begin
            r_b <= w_b_mag;
        end else if (i_shift) begin
            r_b <= r_b >> 1;
        end
    end

    // Accumulator with wrap-around 2N-bit add.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_acc_clr) begin
            r_acc <= '0;
        end else if (i_shift && i_add_en) begin
            r_acc <= r_acc + r_a;
        end
    end

    // Iteration counter bounds the loop at N iterations.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_shift) begin
            r_count <= r_count + COUNT_ONE;
        end
    end

    // Op and result sign are held until the response leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op  <= OP_MUL;
            r_neg <= 1'b0;
        end else if (i_load) begin
            r_op  <= w_op;
            r_neg <= w_a_neg ^ w_b_neg;
        end
    end

    // ---------------------------------------------------------------------
    // Status to control
    // ---------------------------------------------------------------------
    assign o_b_lsb       = r_b[0];
    assign o_b_next_zero = (r_b[N-1:1] == '0);
    assign o_count_done  = (r_count == COUNT_LAST);

    // ---------------------------------------------------------------------
    // Result: re-apply the sign on the full 2N-bit product, then pick a half
    // ---------------------------------------------------------------------
    logic [W2-1:0] w_prod;
    logic [N-1:0]  w_half;

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_half = (r_op == OP_MUL) ? w_prod[N-1:0] : w_prod[W2-1:N];

    assign o_ostream_msg = reset ? '0 : w_half;

endmodule

// File: rtl/lab1_imul_int_mul_var.sv
// -----------------------------------------------------------------------------
// lab1_imul_int_mul_var
// Variable-latency iterative integer multiplier with MUL/MULH/MULHSU/MULHU
// modes and early termination once the remaining multiplier bits are zero.
// Latency is k+1 CALC cycles where k is the MSB index of the effective |b|.
//
// Parameters:
//   p_nbits             operand/result width N (N >= 4)
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   istream_val/rdy     request handshake
//   istream_msg         {op[1:0], a[N-1:0], b[N-1:0]}
//   ostream_val/rdy     response handshake
//   ostream_msg         selected N-bit half of the product
// -----------------------------------------------------------------------------
module lab1_imul_int_mul_var
    import lab1_imul_pkg::*;
#(
    parameter int unsigned p_nbits = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           istream_val,
    output logic                           istream_rdy,
    input  logic [msg_width(p_nbits)-1:0]  istream_msg,
    output logic                           ostream_val,
    input  logic                           ostream_rdy,
    output logic [p_nbits-1:0]             ostream_msg
);

    logic w_load;
    logic w_acc_clr;
    logic w_shift;
    logic w_add_en;
    logic w_b_lsb;
    logic w_b_next_zero;
    logic w_count_done;

    lab1_imul_int_mul_var_ctrl u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .i_istream_val  (istream_val),
        .o_istream_rdy  (istream_rdy),
        .o_ostream_val  (ostream_val),
        .i_ostream_rdy  (ostream_rdy),
        .o_load         (w_load),
        .o_acc_clr      (w_acc_clr),
        .o_shift        (w_shift),
        .o_add_en       (w_add_en),
        .i_b_lsb        (w_b_lsb),
        .i_b_next_zero  (w_b_next_zero),
        .i_count_done   (w_count_done)
    );

    lab1_imul_int_mul_var_dpath #(
        .p_nbits (p_nbits)
    ) u_dpath (
        .clk            (clk),
        .reset          (reset),
        .i_istream_msg  (istream_msg),
        .o_ostream_msg  (ostream_msg),
        .i_load         (w_load),
        .i_acc_clr      (w_acc_clr),
        .i_shift        (w_shift),
        .i_add_en       (w_add_en),
        .o_b_lsb        (w_b_lsb),
        .o_b_next_zero  (w_b_next_zero),
        .o_count_done   (w_count_done)
    );

endmodule
